// File: rtl/parallel_io_bank.sv
// Memory-mapped parallel I/O bank: output registers, synchronised input channels,
// sticky change flags (write-1-to-clear), interrupt mask and a registered interrupt line.
module parallel_io_bank #(
    parameter int              W       = 8,
    parameter int              AW      = 8,
    parameter int              NUM_OUT = 2,
    parameter int              NUM_IN  = 2,
    parameter logic [AW-1:0]   BASE    = 8'hF0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         addr,
    input  logic                  we,
    input  logic [W-1:0]          wdata,
    input  logic [W-1:0]          mem_rdata,
    output logic                  ram_we,
    output logic [W-1:0]          rdata,
    input  logic [NUM_IN*W-1:0]   in_data,
    output logic [NUM_OUT*W-1:0]  out_data,
    output logic                  irq
);

    typedef enum logic [1:0] {WARM0, WARM1, WARM2, ARMED} arm_state_t;

    arm_state_t         state_q, state_d;
    logic               hit;
    logic [3:0]         off;
    logic               io_wr;
    logic [W-1:0]       out_reg [NUM_OUT];
    logic [W-1:0]       sync_s1 [NUM_IN];
    logic [W-1:0]       sync_s2 [NUM_IN];
    logic [W-1:0]       hist_p  [NUM_IN];
    logic [NUM_IN-1:0]  chg, clr, flags, mask;
    logic               irq_q;
    logic [W-1:0]       io_rdata;

    assign hit    = (addr[AW-1:4] == BASE[AW-1:4]);
    assign off    = addr[3:0];
    assign io_wr  = we & hit;
    assign ram_we = we & ~hit;
    assign irq    = irq_q;

    // Warm-up FSM: keeps reset-state history from raising flags until s2/p hold real samples
    always_ff @(posedge clk) begin
        if (rst) state_q <= WARM0;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WARM0:   state_d = WARM1;
            WARM1:   state_d = WARM2;
            WARM2:   state_d = ARMED;
            ARMED:   state_d = ARMED;
            default: state_d = WARM0;
        endcase
    end

    always_comb begin
        chg = '0;
        clr = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            chg[i] = (sync_s2[i] != hist_p[i]) && (state_q == ARMED);
            clr[i] = io_wr && (off == 4'd8) && wdata[i];
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++)
                if (io_wr && (off == 4'(i))) out_reg[i] <= wdata;
        end
    end

    // Input synchroniser (s1 -> s2) and one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_s1[i] <= '0;
                sync_s2[i] <= '0;
                hist_p[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_s1[i] <= in_data[i*W +: W];
                sync_s2[i] <= sync_s1[i];
                hist_p[i]  <= sync_s2[i];
            end
        end
    end

    // Sticky flags: a change in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            flags <= (flags & ~clr) | chg;
            if (io_wr && (off == 4'd9)) mask <= wdata[NUM_IN-1:0];
            irq_q <= |(flags & mask);
        end
    end

    always_comb begin
        io_rdata = '0;
        for (int i = 0; i < NUM_OUT; i++)
            if (off == 4'(i)) io_rdata = out_reg[i];
        for (int i = 0; i < NUM_IN; i++)
            if (off == 4'(4 + i)) io_rdata = sync_s2[i];
        if (off == 4'd8) io_rdata[NUM_IN-1:0] = flags;
        if (off == 4'd9) io_rdata[NUM_IN-1:0] = mask;
    end

    assign rdata = hit ? io_rdata : mem_rdata;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_OUT; i++) out_data[i*W +: W] = out_reg[i];
    end

endmodule

// File: tb/tb_parallel_io_bank.sv
// Directed self-checking bench for parallel_io_bank with default parameters.
module tb_parallel_io_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  mem_rdata;
    logic        ram_we;
    logic [7:0]  rdata;
    logic [15:0] in_data;
    logic [15:0] out_data;
    logic        irq;

    int tests = 0;
    int fails = 0;

    parallel_io_bank dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
        .mem_rdata(mem_rdata), .ram_we(ram_we), .rdata(rdata),
        .in_data(in_data), .out_data(out_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        mem_rdata = 8'hC3; in_data = 16'h3CA5;
        tick(); tick();
        if (out_data !== 16'h0000) begin $display("FAIL reset_out: got %h want %h", out_data, 16'h0000); fails++; end
        tests++;
        if (irq !== 1'b0) begin $display("FAIL reset_irq: got %b want 0", irq); fails++; end
        tests++;
        rd(8'hF8, v);
        if (v !== 8'h00) begin $display("FAIL reset_flags: got %h want 00", v); fails++; end
        tests++;
        rst = 1'b0;
        tick(); tick(); tick();
        rd(8'hF4, v);
        if (v !== 8'hA5) begin $display("FAIL reset_in0: got %h want a5", v); fails++; end
        tests++;
        rd(8'hF5, v);
        if (v !== 8'h3C) begin $display("FAIL reset_in1: got %h want 3c", v); fails++; end
        tests++;
        tick(); tick(); tick();
        rd(8'hF8, v);
        if (v !== 8'h00) begin $display("FAIL warmup_flags: got %h want 00", v); fails++; end
        tests++;
    endtask

    task automatic test_out_write();
        logic [7:0] v;
        addr = 8'hF1; wdata = 8'h5A; we = 1'b1;
        #1;
        if (ram_we !== 1'b0) begin $display("FAIL out_ram_we: got %b want 0", ram_we); fails++; end
        tests++;
        if (rdata !== 8'h00) begin $display("FAIL out_same_cycle_read: got %h want 00", rdata); fails++; end
        tests++;
        tick();
        we = 1'b0;
        if (out_data[15:8] !== 8'h5A) begin $display("FAIL out_data1: got %h want 5a", out_data[15:8]); fails++; end
        tests++;
        rd(8'hF1, v);
        if (v !== 8'h5A) begin $display("FAIL out_readback: got %h want 5a", v); fails++; end
        tests++;
        wr(8'hF3, 8'h77);
        rd(8'hF3, v);
        if (v !== 8'h00) begin $display("FAIL out_unimpl_read: got %h want 00", v); fails++; end
        tests++;
        if (out_data !== 16'h5A00) begin $display("FAIL out_unimpl_write: got %h want 5a00", out_data); fails++; end
        tests++;
    endtask

    task automatic test_passthrough();
        addr = 8'h10; wdata = 8'h11; we = 1'b1; mem_rdata = 8'hC3;
        #1;
        if (ram_we !== 1'b1) begin $display("FAIL pass_10_we: got %b want 1", ram_we); fails++; end
        tests++;
        if (rdata !== 8'hC3) begin $display("FAIL pass_10_rdata: got %h want c3", rdata); fails++; end
        tests++;
        addr = 8'hEF;
        #1;
        if (ram_we !== 1'b1) begin $display("FAIL pass_ef_we: got %b want 1", ram_we); fails++; end
        tests++;
        if (rdata !== 8'hC3) begin $display("FAIL pass_ef_rdata: got %h want c3", rdata); fails++; end
        tests++;
        addr = 8'hF0;
        #1;
        if (ram_we !== 1'b0) begin $display("FAIL pass_f0_we: got %b want 0", ram_we); fails++; end
        tests++;
        if (rdata !== 8'h00) begin $display("FAIL pass_f0_rdata: got %h want 00", rdata); fails++; end
        tests++;
        we = 1'b0;
        tick();
    endtask

    task automatic test_flag_irq();
        logic [7:0] v;
        in_data = 16'h0000;
        tick(); tick(); tick(); tick();
        wr(8'hF8, 8'h03);
        wr(8'hF9, 8'h01);
        tick();
        rd(8'hF9, v);
        if (v !== 8'h01) begin $display("FAIL mask_readback: got %h want 01", v); fails++; end
        tests++;
        rd(8'hF8, v);
        if (v !== 8'h00) begin $display("FAIL flags_cleared_pre: got %h want 00", v); fails++; end
        tests++;
        in_data = 16'h0001;
        tick(); tick();
        rd(8'hF8, v);
        if (v !== 8'h00) begin $display("FAIL flag_early: got %h want 00", v); fails++; end
        tests++;
        tick();
        rd(8'hF8, v);
        if (v !== 8'h01) begin $display("FAIL flag_set_e2: got %h want 01", v); fails++; end
        tests++;
        if (irq !== 1'b0) begin $display("FAIL irq_early: got %b want 0", irq); fails++; end
        tests++;
        tick();
        if (irq !== 1'b1) begin $display("FAIL irq_e3: got %b want 1", irq); fails++; end
        tests++;
        wr(8'hF8, 8'h01);
        rd(8'hF8, v);
        if (v !== 8'h00) begin $display("FAIL flag_clear: got %h want 00", v); fails++; end
        tests++;
        if (irq !== 1'b1) begin $display("FAIL irq_hold_after_clear: got %b want 1", irq); fails++; end
        tests++;
        tick();
        if (irq !== 1'b0) begin $display("FAIL irq_drop: got %b want 0", irq); fails++; end
        tests++;
        in_data = 16'h0101;
        tick(); tick(); tick();
        rd(8'hF8, v);
        if (v !== 8'h02) begin $display("FAIL flag_ch1: got %h want 02", v); fails++; end
        tests++;
        tick(); tick();
        if (irq !== 1'b0) begin $display("FAIL irq_masked_ch1: got %b want 0", irq); fails++; end
        tests++;
    endtask

    task automatic test_set_clear();
        logic [7:0] v;
        in_data = 16'h0100;
        tick(); tick();
        wr(8'hF8, 8'h01);
        rd(8'hF8, v);
        if (v !== 8'h03) begin $display("FAIL set_wins_over_clear: got %h want 03", v); fails++; end
        tests++;
    endtask

    task automatic test_reset_midop();
        logic [7:0] v;
        wr(8'hF9, 8'h03);
        tick();
        if (irq !== 1'b1) begin $display("FAIL midop_pre_irq: got %b want 1", irq); fails++; end
        tests++;
        if (out_data !== 16'h5A00) begin $display("FAIL midop_pre_out: got %h want 5a00", out_data); fails++; end
        tests++;
        rst = 1'b1; addr = 8'hF1; wdata = 8'hFF; we = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0;
        if (out_data !== 16'h0000) begin $display("FAIL midop_out: got %h want 0000", out_data); fails++; end
        tests++;
        if (irq !== 1'b0) begin $display("FAIL midop_irq: got %b want 0", irq); fails++; end
        tests++;
        rd(8'hF8, v);
        if (v !== 8'h00) begin $display("FAIL midop_flags: got %h want 00", v); fails++; end
        tests++;
        rd(8'hF9, v);
        if (v !== 8'h00) begin $display("FAIL midop_mask: got %h want 00", v); fails++; end
        tests++;
        // in_data ch1 is nonzero, so a warm-up that did not restart would flag it
        tick(); tick(); tick(); tick(); tick();
        rd(8'hF8, v);
        if (v !== 8'h00) begin $display("FAIL midop_warmup: got %h want 00", v); fails++; end
        tests++;
        rd(8'hF5, v);
        if (v !== 8'h01) begin $display("FAIL midop_in1: got %h want 01", v); fails++; end
        tests++;
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_passthrough();
        test_flag_irq();
        test_set_clear();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
